// File: rtl/hdlverifier_jtag_dr_responder.sv
// hdlverifier_jtag_dr_responder
// User data-register engine behind a JTAG BSCAN wrapper, entirely in the tck
// domain. Host scans are deserialized into commands (NOP / WRITE / READ-ACK /
// CLEAR). WRITE payloads go through a small command FIFO. A single holding
// register returns one response word, plus status, on the next capture.
//
// Ports:
//   tck, jtag_reset                  clock (rising edge), async active-high reset
//   tdi, tdo                         serial in/out, LSB first; tdo = sr[0]
//   capture_dr, shift_dr, update_dr  TAP strobes, already qualified by select
//   cmd_data, cmd_valid, cmd_ready   command FIFO head, popped on valid&&ready
//   rsp_data, rsp_valid, rsp_ready   response offer; rsp_ready = !hold_valid
//   overflow, frame_err              sticky error flags, cleared by CLEAR
module hdlverifier_jtag_dr_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  tck,
  input  logic                  jtag_reset,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  output logic                  overflow,
  output logic                  frame_err
);
  localparam int L  = DATA_WIDTH + 4;
  localparam int BW = $clog2(L + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BCNT_L   = BW'(L);
  localparam logic [BW-1:0] BCNT_MAX = BW'(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ACK   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [L-1:0]                           sr;
  logic [BW-1:0]                          bcnt;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]  mem;
  logic [PW-1:0]                          wptr, rptr;
  logic [CW-1:0]                          count;
  logic [DATA_WIDTH-1:0]                  hold_data;
  logic                                   hold_valid;

  logic       fifo_full, pop, upd, len_ok, cmd_ok, push, drop;
  logic [1:0] op;

  assign tdo       = sr[0];
  assign fifo_full = (count == CNT_FULL);
  assign cmd_valid = (count != '0);
  // Gate the head so an empty FIFO shows zero rather than a stale entry.
  assign cmd_data  = cmd_valid ? mem[rptr] : '0;
  assign rsp_ready = !hold_valid;
  assign pop       = cmd_valid && cmd_ready;

  // Update only acts when no higher-priority strobe is present.
  assign upd    = update_dr && !capture_dr && !shift_dr;
  assign len_ok = (bcnt == BCNT_L);
  assign cmd_ok = upd && len_ok;
  assign op     = sr[DATA_WIDTH+1:DATA_WIDTH];
  // A same-cycle pop frees a slot, so a full FIFO still accepts the word.
  assign push   = cmd_ok && (op == OP_WRITE) && (!fifo_full || pop);
  assign drop   = cmd_ok && (op == OP_WRITE) && fifo_full && !pop;

  always_ff @(posedge tck or posedge jtag_reset) begin
    if (jtag_reset) begin
      sr         <= '0;
      bcnt       <= '0;
      mem        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (capture_dr) begin
        sr   <= {frame_err, overflow, fifo_full, hold_valid, hold_data};
        bcnt <= '0;
      end else if (shift_dr) begin
        sr <= {tdi, sr[L-1:1]};
        if (bcnt != BCNT_MAX) bcnt <= bcnt + 1'b1;
      end

      if (push) begin
        mem[wptr] <= sr[DATA_WIDTH-1:0];
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (drop)              overflow  <= 1'b1;
      if (upd && !len_ok)    frame_err <= 1'b1;
      // Written last so CLEAR beats any same-cycle set.
      if (cmd_ok && op == OP_CLEAR) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end

      if (cmd_ok && op == OP_ACK) hold_valid <= 1'b0;
      // Acceptance requires hold_valid == 0, so it never races a real ACK.
      if (rsp_valid && rsp_ready) begin
        hold_data  <= rsp_data;
        hold_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hdlverifier_jtag_dr_responder.sv
module tb_hdlverifier_jtag_dr_responder;
  localparam int DW = 32;
  localparam int L  = DW + 4;

  logic          tck = 1'b0;
  logic          jtag_reset = 1'b1;
  logic          tdi = 1'b0, tdo;
  logic          capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic [DW-1:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready, overflow, frame_err;

  int checks = 0;
  int errors = 0;

  hdlverifier_jtag_dr_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .tck(tck), .jtag_reset(jtag_reset), .tdi(tdi), .tdo(tdo),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck); #1;
  endtask

  // Capture, shift nbits of din (LSB first) while collecting tdo, then update.
  // pop_upd raises cmd_ready during the update cycle only.
  task automatic scan(input logic [L-1:0] din, input int nbits, input logic pop_upd,
                      output logic [L-1:0] dout);
    dout = '0;
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < L) begin dout[i] = tdo; tdi = din[i]; end
      else tdi = 1'b0;
      shift_dr = 1'b1; tick();
    end
    shift_dr = 1'b0; tdi = 1'b0;
    update_dr = 1'b1; cmd_ready = pop_upd; tick();
    update_dr = 1'b0; cmd_ready = 1'b0;
  endtask

  function automatic logic [L-1:0] frame(input logic [1:0] op, input logic [DW-1:0] d);
    return {2'b00, op, d};
  endfunction

  task automatic pop_one();
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [L-1:0] d;
    repeat (2) tick();
    jtag_reset = 1'b0; tick();
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", tdo); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if (cmd_data !== '0) begin errors++; $display("FAIL reset_cmd_data got %h exp 0", cmd_data); end
    checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready got %b exp 1", rsp_ready); end
    checks++; if ({overflow, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, frame_err}); end
    scan('0, L, 1'b0, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL reset_stream got %h exp 0", d); end
    checks++; if (rsp_ready !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL nop_outputs got rdy=%b vld=%b exp 1 0", rsp_ready, cmd_valid); end
  endtask

  task automatic test_write();
    logic [L-1:0] d;
    scan(frame(2'b01, 32'hDEADBEEF), L, 1'b0, d);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL write_valid got %b exp 1", cmd_valid); end
    checks++; if (cmd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data got %h exp deadbeef", cmd_data); end
    pop_one();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL write_pop got %b exp 0", cmd_valid); end
  endtask

  task automatic test_overflow();
    logic [L-1:0] d;
    for (int i = 1; i <= 5; i++) scan(frame(2'b01, DW'(i)), L, 1'b0, d);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    scan(frame(2'b00, '0), L, 1'b0, d);
    checks++; if (d[L-1:L-4] !== 4'b0110) begin errors++; $display("FAIL ovf_status got %b exp 0110", d[L-1:L-4]); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (cmd_valid !== 1'b1 || cmd_data !== DW'(i)) begin errors++; $display("FAIL ovf_pop%0d got v=%b %h exp 1 %h", i, cmd_valid, cmd_data, DW'(i)); end
      pop_one();
    end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", cmd_valid); end
    scan(frame(2'b11, '0), L, 1'b0, d);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_response();
    logic [L-1:0] d;
    rsp_data = 32'h12345678; rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL rsp_accept got %b exp 0", rsp_ready); end
    rsp_data = 32'hCAFEF00D; rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    scan(frame(2'b10, '0), L, 1'b0, d);
    checks++; if (d[DW-1:0] !== 32'h12345678) begin errors++; $display("FAIL rsp_word got %h exp 12345678", d[DW-1:0]); end
    checks++; if (d[DW] !== 1'b1) begin errors++; $display("FAIL rsp_hold_bit got %b exp 1", d[DW]); end
    checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL rsp_ack got %b exp 1", rsp_ready); end
  endtask

  task automatic test_frame();
    logic [L-1:0] d;
    scan(frame(2'b01, 32'h11111111), L - 1, 1'b0, d);
    checks++; if (frame_err !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL short_scan got fe=%b v=%b exp 1 0", frame_err, cmd_valid); end
    scan(frame(2'b01, 32'h22222222), L + 3, 1'b0, d);
    checks++; if (frame_err !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL long_scan got fe=%b v=%b exp 1 0", frame_err, cmd_valid); end
    scan(frame(2'b01, 32'hA5A50F0F), L, 1'b0, d);
    checks++; if (d[L-1] !== 1'b1) begin errors++; $display("FAIL fe_status got %b exp 1", d[L-1]); end
    checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hA5A50F0F) begin errors++; $display("FAIL exact_write got v=%b %h exp 1 a5a50f0f", cmd_valid, cmd_data); end
    pop_one();
    scan(frame(2'b11, '0), L, 1'b0, d);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_clear got %b exp 0", frame_err); end
  endtask

  task automatic test_full_pop();
    logic [L-1:0] d;
    for (int i = 0; i < 4; i++) scan(frame(2'b01, DW'(32'h10 + i)), L, 1'b0, d);
    scan(frame(2'b01, 32'h14), L, 1'b1, d);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got %b exp 0", overflow); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (cmd_valid !== 1'b1 || cmd_data !== DW'(32'h10 + i)) begin errors++; $display("FAIL full_pop_drain%0d got v=%b %h exp 1 %h", i, cmd_valid, cmd_data, DW'(32'h10 + i)); end
      pop_one();
    end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty got %b exp 0", cmd_valid); end
  endtask

  task automatic test_reset_mid();
    logic [L-1:0] d;
    scan(frame(2'b01, 32'h55AA55AA), L, 1'b0, d);
    scan(frame(2'b00, '0), 5, 1'b0, d);
    rsp_data = 32'hFFFFFFFF; rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    tdi = 1'b1; shift_dr = 1'b1; tick(); tick();
    #2 jtag_reset = 1'b1; #1;
    checks++; if ({tdo, cmd_valid, rsp_ready, overflow, frame_err} !== 5'b00100) begin errors++; $display("FAIL mid_reset got %b exp 00100", {tdo, cmd_valid, rsp_ready, overflow, frame_err}); end
    checks++; if (cmd_data !== '0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", cmd_data); end
    shift_dr = 1'b0; tdi = 1'b0;
    tick(); jtag_reset = 1'b0; tick();
    scan(frame(2'b00, '0), L, 1'b0, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL post_reset_stream got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_overflow();
    test_response();
    test_frame();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdlverifier_jtag_dr_responder.md
# hdlverifier_jtag_dr_responder

User data-register engine that sits on the TAP-side outputs of the JTAG BSCAN wrapper: tdi, tck, jtag_reset, capture_dr, shift_dr and update_dr in, tdo back out. It deserializes host scans into commands for the data-capture logic and serializes a response word with status back to the host. Writes go through a small command FIFO. Reads use a single response holding register with a capture/acknowledge protocol. Everything runs in the tck domain.

## Interface
- DATA_WIDTH, 32, payload width of command and response words.
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2).
- tck  input  1  JTAG clock; all logic on rising edge.
- jtag_reset  input  1  reset, asynchronous, active-high.
- tdi  input  1  serial data from host.
- tdo  output  1  serial data to host; equals sr[0] (from register, no added logic).
- capture_dr  input  1  capture-DR qualified by select.
- shift_dr  input  1  shift-DR qualified by select.
- update_dr  input  1  update-DR qualified by select.
- cmd_data  output  DATA_WIDTH  FIFO head word.
- cmd_valid  output  1  FIFO not empty.
- cmd_ready  input  1  consumer pop; pop when cmd_valid && cmd_ready.
- rsp_data  input  DATA_WIDTH  response word from capture logic.
- rsp_valid  input  1  response offered.
- rsp_ready  output  1  = !hold_valid.
- overflow  output  1  sticky: WRITE dropped because FIFO full.
- frame_err  output  1  sticky: update with wrong scan length.

## Operation
- DR length L = DATA_WIDTH+4. Shift register sr[L-1:0] and bit counter bcnt (saturates at L+1).
- Capture (capture_dr): sr <= {frame_err, overflow, fifo_full, hold_valid, hold_data}. Bit 0 is hold_data[0]. bcnt <= 0.
- Shift (shift_dr): sr <= {tdi, sr[L-1:1]}. bcnt <= min(bcnt+1, L+1). Data is LSB-first in and out.
- Update (update_dr):
  - If bcnt != L, no command runs and frame_err is set.
  - Otherwise decode op = sr[DATA_WIDTH+1:DATA_WIDTH]. Bits L-1:L-2 are reserved and ignored.
  - 00 NOP: no action.
  - 01 WRITE: push sr[DATA_WIDTH-1:0] into the FIFO. If the FIFO is full and no pop happens in the same cycle, drop the word and set overflow.
  - 10 READ-ACK: clear hold_valid. No effect if hold_valid is already 0.
  - 11 CLEAR: clear overflow and frame_err. If the same cycle would also set a sticky, the clear wins.
- Priority if strobes overlap (illegal from the TAP): capture > shift > update. Only the highest-priority strobe acts.
- Response hold: when rsp_valid && rsp_ready, hold_data <= rsp_data and hold_valid <= 1.
- Host read sequence: scan once to capture the word and status; a later scan's READ-ACK releases the hold.
- FIFO: circular buffer with read/write pointers and a count.
  - fifo_full means count == FIFO_DEPTH.
  - A push and a pop in the same cycle keep the count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: sr = 0 (tdo = 0), bcnt = 0, FIFO empty (cmd_valid = 0, cmd_data = 0), hold_valid = 0 (rsp_ready = 1), hold_data = 0, overflow = 0, frame_err = 0.
- Asserting jtag_reset mid-scan or mid-handshake clears all state immediately. Any FIFO contents and any held response are lost.
- tdo changes on the tck edge after each shift. The bit presented after capture is hold_data[0].
- Command latency: cmd_valid is high on the first tck edge after the update cycle of a WRITE into an empty FIFO.
- Response latency: rsp_ready falls on the edge after acceptance. It rises on the edge after the update cycle of a READ-ACK.
- Sticky flags change on the edge closing the update cycle. They are visible in the next capture.

## Test plan
- Reset, then capture plus L shifts of zeros → tdo stream is all zeros; rsp_ready = 1, cmd_valid = 0.
- Scan WRITE of 0xDEADBEEF (op = 01) with cmd_ready = 0 → cmd_valid = 1 and cmd_data = 0xDEADBEEF on the edge after update.
- 5 WRITEs of 1..5 with cmd_ready = 0 (FIFO_DEPTH = 4) → 4 held words, overflow = 1. Popping returns 1, 2, 3, 4 in order. CLEAR clears overflow.
- Drive rsp_data = 0x12345678 with rsp_valid → next scan's captured bits 31:0 read 0x12345678 and bit 32 = 1. A READ-ACK on that scan gives rsp_ready = 1 the next edge.
- Scan L-1 bits and update → no FIFO push, frame_err = 1. Scan L+3 bits and update → still error. An exact-length WRITE afterwards succeeds.
- FIFO full while a WRITE update coincides with cmd_ready = 1 → word accepted, count stays 4, overflow stays 0. Mid-scan jtag_reset → all outputs return to their reset values.
